// File: rtl/disp_pkg.sv
// Shared display definitions for the scanned 7-segment path.
//   DISP_BLANK_OFF / DISP_BLANK_ON : decoder enable levels (1 = segments off, 0 = on)
//   DIGIT_OFF                      : active-low all-ones digit select; slice to width
//   hex_digit_t                    : one hex nibble
package disp_pkg;

   localparam logic DISP_BLANK_OFF = 1'b1;
   localparam logic DISP_BLANK_ON  = 1'b0;

   // Wide enough for any realistic digit count; users slice [DIGITS-1:0].
   localparam logic [63:0] DIGIT_OFF = '1;

   typedef logic [3:0] hex_digit_t;

endpackage

// File: rtl/scan_prescaler.sv
// Scan-rate divider: counts 0..DIV-1 and wraps. tick is high combinationally
// while the count sits at DIV-1, so the consumer acts on the wrapping edge.
//   clk  : system clock
//   rst  : async active-high reset, count returns to 0
//   tick : one-cycle strobe every DIV cycles
module scan_prescaler #(
   parameter int DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = (cnt_q == CNT_LAST);
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/hex_scan_mux.sv
// Time-multiplexed scan controller for common-anode 7-segment digits.
// Latches a hex word through a pending/shadow double buffer (the shadow only
// changes on a frame boundary) and steps one digit per prescaler tick.
//   clk, rst    : clock, async active-high reset
//   data_in     : word to show, digit k = data_in[4k+3:4k], digit 0 rightmost
//   load        : one-cycle capture request for data_in
//   nibble      : hex value of the selected digit (to decoder in)
//   blank       : decoder enable, 1 = segments off
//   digit_en    : active-low one-cold digit select
//   frame_done  : one-cycle pulse after each completed frame
// Optional macro HEX_SCAN_LZB_EN: leading-zero blanking on digits above 0.
module hex_scan_mux
   import disp_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int DIV    = 50000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   data_in,
   input  logic                  load,
   output hex_digit_t            nibble,
   output logic                  blank,
   output logic [DIGITS-1:0]     digit_en,
   output logic                  frame_done
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   logic tick;

   scan_prescaler #(.DIV(DIV)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   logic [IW-1:0]         idx_q, idx_d;
   logic [4*DIGITS-1:0]   pending_q, pending_d;
   logic                  pend_v_q, pend_v_d;
   logic [4*DIGITS-1:0]   shadow_q, shadow_d;
   hex_digit_t            nibble_q, nibble_d;
   logic                  blank_q, blank_d;
   logic [DIGITS-1:0]     digit_en_q, digit_en_d;
   logic                  frame_done_q, frame_done_d;

   logic                  boundary;
   hex_digit_t            nib_sel;
   logic [DIGITS-1:0]     en_sel;
   logic                  blank_sel;

   // Index and double buffer. idx_d is the post-tick index used for the
   // output registers; shadow_d is the bypassed shadow so digit 0 of a new
   // frame already shows the new word.
   always_comb begin
      idx_d     = idx_q;
      pending_d = pending_q;
      pend_v_d  = pend_v_q;
      shadow_d  = shadow_q;
      boundary  = tick && (idx_q == IDX_LAST);

      if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

      if (boundary) begin
         // A load on the boundary is the newest word, so it beats pending.
         if (load)          shadow_d = data_in;
         else if (pend_v_q) shadow_d = pending_q;
         pend_v_d = 1'b0;
      end else if (load) begin
         pending_d = data_in;
         pend_v_d  = 1'b1;
      end
   end

   // Digit select and nibble mux for the post-tick index.
   always_comb begin
      nib_sel = '0;
      en_sel  = '1;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx_d == IW'(k)) begin
            nib_sel   = shadow_d[4*k +: 4];
            en_sel[k] = 1'b0;
         end
      end
   end

`ifdef HEX_SCAN_LZB_EN
   // Walk from the top digit down, tracking whether every nibble from k up
   // is zero; digit 0 is never visited, so it is always lit.
   always_comb begin
      logic all_zero;
      all_zero  = 1'b1;
      blank_sel = DISP_BLANK_ON;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         all_zero = all_zero & (shadow_d[4*k +: 4] == 4'h0);
         if (idx_d == IW'(k) && all_zero) blank_sel = DISP_BLANK_OFF;
      end
   end
`else
   assign blank_sel = DISP_BLANK_ON;
`endif

   always_comb begin
      nibble_d     = nibble_q;
      blank_d      = blank_q;
      digit_en_d   = digit_en_q;
      frame_done_d = boundary;
      if (tick) begin
         nibble_d   = nib_sel;
         blank_d    = blank_sel;
         digit_en_d = en_sel;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q        <= IDX_LAST;
         pending_q    <= '0;
         pend_v_q     <= 1'b0;
         shadow_q     <= '0;
         nibble_q     <= '0;
         blank_q      <= DISP_BLANK_OFF;
         digit_en_q   <= DIGIT_OFF[DIGITS-1:0];
         frame_done_q <= 1'b0;
      end else begin
         idx_q        <= idx_d;
         pending_q    <= pending_d;
         pend_v_q     <= pend_v_d;
         shadow_q     <= shadow_d;
         nibble_q     <= nibble_d;
         blank_q      <= blank_d;
         digit_en_q   <= digit_en_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign nibble     = nibble_q;
   assign blank      = blank_q;
   assign digit_en   = digit_en_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_scan_mux.sv
module tb_hex_scan_mux;
   localparam int DIGITS = 4;
   localparam int DIV    = 4;
   localparam int W      = 4 * DIGITS;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [W-1:0]      data_in = '0;
   logic              load = 1'b0;
   logic [3:0]        nibble;
   logic              blank;
   logic [DIGITS-1:0] digit_en;
   logic              frame_done;

   hex_scan_mux #(.DIGITS(DIGITS), .DIV(DIV)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .load(load),
      .nibble(nibble), .blank(blank), .digit_en(digit_en), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: counts edges since reset release and ticks taken.
   // The word on display changes only when a new frame starts, taking the
   // most recent load seen since the previous frame start.
   int           m_cyc, m_ticks;
   logic [W-1:0] m_word, m_last;
   logic         m_have, m_fd;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cyc = 0; m_ticks = 0; m_word = '0; m_last = '0; m_have = 1'b0; m_fd = 1'b0;
   endtask

   task automatic model_edge(input logic ld, input logic [W-1:0] d);
      m_cyc++;
      m_fd = 1'b0;
      if (ld) begin m_last = d; m_have = 1'b1; end
      if (m_cyc % DIV == 0) begin
         m_ticks++;
         if ((m_ticks - 1) % DIGITS == 0) begin
            if (m_have) m_word = m_last;
            m_have = 1'b0;
            m_fd   = 1'b1;
         end
      end
   endtask

   function automatic int cur_digit();
      return (m_ticks - 1) % DIGITS;
   endfunction

   task automatic check_all();
      int dig;
      logic [DIGITS-1:0] e_en;
      logic [3:0] e_nib;
      logic e_blank;
      if (m_ticks == 0) begin
         e_en = '1; e_nib = 4'h0; e_blank = 1'b1;
      end else begin
         dig     = cur_digit();
         e_en    = ~(DIGITS'(1) << dig);
         e_nib   = 4'((m_word >> (4 * dig)) & 16'hF);
`ifdef HEX_SCAN_LZB_EN
         e_blank = (dig > 0) && ((m_word >> (4 * dig)) == 0);
`else
         e_blank = 1'b0;
`endif
      end
      check("digit_en", 32'(digit_en), 32'(e_en));
      check("nibble", 32'(nibble), 32'(e_nib));
      check("blank", 32'(blank), 32'(e_blank));
      check("frame_done", 32'(frame_done), 32'(m_fd));
   endtask

   task automatic step(input logic ld, input logic [W-1:0] d);
      load = ld; data_in = d;
      @(posedge clk);
      model_edge(ld, d);
      #1;
      load = 1'b0;
      check_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0);
   endtask

   // Advance until the next edge is a frame boundary.
   task automatic align_boundary();
      int guard;
      guard = 0;
      while (!(((m_cyc + 1) % DIV == 0) && (m_ticks % DIGITS == 0)) && guard < 100) begin
         step(1'b0, '0);
         guard++;
      end
      check("align_bound", 32'(guard < 100), 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
   endtask

   initial begin
      model_reset();
      do_reset();

      // Reset state, then idle through the first tick.
      check("rst_digit_en", 32'(digit_en), 32'hF);
      check("rst_blank", 32'(blank), 32'd1);
      check("rst_nibble", 32'(nibble), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      run(4);
      check("first_tick_en", 32'(digit_en), 32'hE);
      check("first_tick_fd", 32'(frame_done), 32'd1);
      run(2 * DIGITS * DIV);

      // Plain load mid-frame, shown from the next boundary.
      run(3);
      step(1'b1, 16'h1A3F);
      align_boundary();
      step(1'b0, '0);
      check("1A3F_d0", 32'(nibble), 32'hF);
      run(DIGITS * DIV * 2);

      // Mid-frame replacement does not tear the current frame.
      align_boundary();
      step(1'b1, 16'hABCD);
      run(DIV + 1);
      step(1'b1, 16'h1234);
      run(2 * DIGITS * DIV);

      // Load on the boundary edge is visible on digit 0 immediately.
      align_boundary();
      step(1'b1, 16'h5678);
      check("5678_bypass", 32'(nibble), 32'h8);
      run(DIGITS * DIV);

      // Leading-zero patterns and last-load-wins.
      align_boundary();
      step(1'b1, 16'h0042);
      run(DIGITS * DIV);
      step(1'b1, 16'h9999);
      step(1'b1, 16'h0000);
      align_boundary();
      run(DIGITS * DIV + 1);

      // Async reset during digit 2 with a load pending.
      align_boundary();
      step(1'b1, 16'h4321);
      run(2 * DIV);
      step(1'b1, 16'h7777);
      #2 rst = 1'b1;
      #1;
      check("arst_digit_en", 32'(digit_en), 32'hF);
      check("arst_blank", 32'(blank), 32'd1);
      check("arst_nibble", 32'(nibble), 32'd0);
      check("arst_frame_done", 32'(frame_done), 32'd0);
      do_reset();
      run(2 * DIGITS * DIV);

      // Random loads, including ones that land on boundaries.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 5) == 0) step(1'b1, W'($urandom));
         else                           step(1'b0, '0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/hex_scan_mux.md
# hex_scan_mux

Time-multiplexed scan controller for a bank of common-anode 7-segment digits. It latches a multi-digit hex word and cycles through the digits at a divided scan rate. On each scan step it presents one nibble plus a blank flag to the downstream hex-to-segment decoder (`in`/`enable` of that decoder) and drives the one-cold digit-select lines. It sits between the SRAM data/address path and the segment decoder on the board display.

## Interface
- `DIGITS`, default 4: number of digits scanned; must be ≥ 2.
- `DIV`, default 50000: clk cycles per scan step; must be ≥ 2.
- `clk`  in  1: system clock, rising-edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `data_in`  in  4*DIGITS: word to display; digit k = `data_in[4k+3:4k]`; digit 0 is rightmost.
- `load`  in  1: single-cycle request to capture `data_in`.
- `nibble`  out  4: hex value of the currently selected digit, to the decoder `in`.
- `blank`  out  1: decoder enable, active-low semantics (1 = segments off, 0 = on).
- `digit_en`  out  DIGITS: digit select, active-low, one-cold; all ones = no digit lit.
- `frame_done`  out  1: one-cycle pulse after each completed scan frame.

## Operation
- Prescaler `cnt` counts 0..DIV-1 and wraps. `tick` is asserted when `cnt == DIV-1`.
- Digit index `idx` advances by 1 on each tick, from DIGITS-1 wrapping to 0.
- A **frame boundary** is the tick on which `idx` wraps from DIGITS-1 to 0.
- Double buffering:
  - `load` copies `data_in` into `pending` and sets `pend_v`.
  - At each frame boundary with `pend_v` = 1, `shadow <= pending` and `pend_v` is cleared.
  - If `load` coincides with a frame boundary, `data_in` goes straight to `shadow` and `pend_v` stays 0.
  - The display never shows a mixed frame.
- Multiple loads within a frame: the last one wins.
- Outputs are registered and updated only on tick, using the post-tick `idx` (called `idx_n`):
  - `digit_en <= ~(1 << idx_n)`
  - `nibble <= shadow_n[4*idx_n +: 4]`, where `shadow_n` is the shadow value being written that same edge. This bypass means digit 0 of a new frame already shows new data.
  - `blank <= 0`, or the leading-zero rule under Configuration.
- `frame_done` is 1 for exactly the cycle following a frame-boundary edge.
- Reset values:
  - `cnt` = 0, `idx` = DIGITS-1, `pending` = 0, `pend_v` = 0, `shadow` = 0.
  - `nibble` = 0, `blank` = 1, `digit_en` = all ones, `frame_done` = 0.
- Reset asserted mid-frame returns to these values immediately. Pending loads are discarded.

## Timing
- The first tick after reset occurs DIV cycles after reset deassertion, i.e. on the edge where `cnt` reaches DIV-1. That tick is a frame boundary (`idx` goes DIGITS-1 → 0), so `frame_done` pulses on it.
- Each digit is lit for exactly DIV cycles; a frame lasts DIGITS*DIV cycles.
- Latency from `load` to visibility is at most one frame plus one step, at least 0 steps (coincident with a boundary).
- Exactly one digit is active-low at any time after the first tick. There is no overlap cycle.

## Configuration
- Macro `HEX_SCAN_LZB_EN` enables leading-zero blanking.
  - When defined, `blank <= 1` for digit `idx_n` if `idx_n > 0` and all nibbles of `shadow_n` from `idx_n` up to DIGITS-1 are zero. Digit 0 is never blanked. `digit_en` is unaffected.
- When not defined, `blank` is 0 on every digit after the first tick. No blanking logic is synthesized.

## Structure
- A shared package `disp_pkg` holds:
  - the `DISP_BLANK_OFF` = 1 and `DISP_BLANK_ON` = 0 constants;
  - the `DIGIT_OFF` active-low all-ones helper;
  - a `hex_digit_t` 4-bit typedef.
- Sub-module `scan_prescaler` (parameter `DIV`; ports `clk`, `rst`, `tick`) contains the divider.
- The top contains the index, buffering and output registers.

## Test plan
- Reset then idle, DIGITS=4, DIV=4: `digit_en`=4'b1111 and `blank`=1 for cycles 0–3. First tick at cycle 4 gives `digit_en`=4'b1110, `nibble`=0, `frame_done` pulse.
- `load` with `data_in`=16'h1A3F: after the next boundary the four steps show `nibble` F, 3, A, 1 with `digit_en` 1110, 1101, 1011, 0111, each for 4 cycles.
- Load 16'h1234 mid-frame while 16'hABCD is displayed: remaining digits of the frame still show ABCD nibbles; the next frame is entirely 1234.
- `load` asserted on the frame-boundary cycle with 16'h5678: digit 0 in that same step shows 8.
- `HEX_SCAN_LZB_EN` defined, `data_in`=16'h0042: `blank` = 0, 0, 1, 1 for digits 0–3. With `data_in`=16'h0000, only digit 0 is unblanked and shows 0.
- Assert `rst` during digit 2 with a pending load: outputs return to reset values within the same cycle, and the subsequent frame shows 0000.
